// File: rtl/decode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl_if
// Brief    : Decode-stage bus between fetch/decode and the decode controller.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instrD;
    logic             validD;
    logic [31:0]      immD;
    logic             flushE;
    logic [2:0]       immSelD;
    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             validE;
    logic             regWriteE;
    logic             memWriteE;
    logic             memReadE;
    logic             aluSrcE;
    logic             branchE;
    logic             jumpE;
    logic [1:0]       resultSrcE;
    logic [1:0]       aluOpE;
    logic [2:0]       funct3E;
    logic             funct7bE;
    logic [4:0]       rdE;
    logic [4:0]       rs1E;
    logic [4:0]       rs2E;
    logic [31:0]      immE;
    logic             illegalE;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output instrD, validD, immD, flushE,
        input  immSelD, stallF, stallD, flushD, validE, regWriteE, memWriteE,
               memReadE, aluSrcE, branchE, jumpE, resultSrcE, aluOpE, funct3E,
               funct7bE, rdE, rs1E, rs2E, immE, illegalE, stallCnt, flushCnt
    );

    modport slave (
        input  instrD, validD, immD, flushE,
        output immSelD, stallF, stallD, flushD, validE, regWriteE, memWriteE,
               memReadE, aluSrcE, branchE, jumpE, resultSrcE, aluOpE, funct3E,
               funct7bE, rdE, rs1E, rs2E, immE, illegalE, stallCnt, flushCnt
    );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl
// Brief    : Decode controller: opcode decode, ID/EX control register,
//            load-use hazard stall, branch flush and debug event counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    decode_ctrl_if.slave bus
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [2:0] c_IMM_I    = 3'b000;
    localparam logic [2:0] c_IMM_B    = 3'b001;
    localparam logic [2:0] c_IMM_J    = 3'b010;
    localparam logic [2:0] c_IMM_S    = 3'b011;
    localparam logic [2:0] c_IMM_U    = 3'b100;
    localparam logic [2:0] c_IMM_NONE = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic [1:0]  result_src;
        logic [1:0]  alu_op;
        logic [2:0]  funct3;
        logic        funct7b;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    ctrl_t            w_dec;
    ctrl_t            w_e_d;
    ctrl_t            r_e_q;
    logic [2:0]       w_imm_sel;
    logic             w_use_rs1;
    logic             w_use_rs2;
    logic             w_hazard;
    logic             w_stall;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] w_flush_cnt_d;
    logic [CNT_W-1:0] r_flush_cnt_q;
    logic             w_unused_bits;

    assign w_unused_bits = &{1'b0, bus.instrD[31], bus.instrD[29:25]};

    always_comb begin
        w_dec         = '0;
        w_imm_sel     = c_IMM_NONE;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        w_dec.valid   = bus.validD;
        w_dec.funct3  = bus.instrD[14:12];
        w_dec.funct7b = bus.instrD[30];
        w_dec.rd      = bus.instrD[11:7];
        w_dec.rs1     = bus.instrD[19:15];
        w_dec.rs2     = bus.instrD[24:20];
        w_dec.imm     = bus.immD;
        case (bus.instrD[6:0])
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm_sel       = c_IMM_U;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            c_OP_JAL: begin
                w_imm_sel        = c_IMM_J;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 1'b1;
            end
            c_OP_JALR: begin
                w_imm_sel        = c_IMM_I;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 1'b1;
                w_use_rs1        = 1'b1;
            end
            c_OP_BRANCH: begin
                w_imm_sel    = c_IMM_B;
                w_dec.alu_op = 2'b01;
                w_dec.branch = 1'b1;
                w_use_rs1    = 1'b1;
                w_use_rs2    = 1'b1;
            end
            c_OP_LOAD: begin
                w_imm_sel        = c_IMM_I;
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b01;
                w_use_rs1        = 1'b1;
            end
            c_OP_STORE: begin
                w_imm_sel       = c_IMM_S;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_use_rs1       = 1'b1;
                w_use_rs2       = 1'b1;
            end
            c_OP_IMM: begin
                w_imm_sel       = c_IMM_I;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_op    = 2'b10;
                w_use_rs1       = 1'b1;
            end
            c_OP_REG: begin
                w_imm_sel       = c_IMM_NONE;
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = 2'b10;
                w_use_rs1       = 1'b1;
                w_use_rs2       = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        // A bubble in D keeps its fields but must not enable anything in EX.
        if (!bus.validD) begin
            w_dec.reg_write  = 1'b0;
            w_dec.mem_write  = 1'b0;
            w_dec.mem_read   = 1'b0;
            w_dec.alu_src    = 1'b0;
            w_dec.branch     = 1'b0;
            w_dec.jump       = 1'b0;
            w_dec.result_src = 2'b00;
            w_dec.alu_op     = 2'b00;
            w_dec.illegal    = 1'b0;
        end
    end

    // Writes to x0 never produce a value, so a load to x0 cannot cause a stall.
    assign w_hazard = r_e_q.valid && r_e_q.mem_read && (r_e_q.rd != 5'd0) && bus.validD &&
                      ((w_use_rs1 && (r_e_q.rd == bus.instrD[19:15])) ||
                       (w_use_rs2 && (r_e_q.rd == bus.instrD[24:20])));
    assign w_stall  = w_hazard && !bus.flushE;

    always_comb begin
        w_e_d         = w_dec;
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (bus.flushE || w_hazard) begin
            w_e_d = '0;
        end
        if (w_stall && (r_stall_cnt_q != {CNT_W{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
        if (bus.flushE && (r_flush_cnt_q != {CNT_W{1'b1}})) begin
            w_flush_cnt_d = r_flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_q         <= '0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_e_q         <= w_e_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign bus.immSelD   = w_imm_sel;
    assign bus.stallF    = w_stall;
    assign bus.stallD    = w_stall;
    assign bus.flushD    = bus.flushE;
    assign bus.validE    = r_e_q.valid;
    assign bus.regWriteE = r_e_q.reg_write;
    assign bus.memWriteE = r_e_q.mem_write;
    assign bus.memReadE  = r_e_q.mem_read;
    assign bus.aluSrcE   = r_e_q.alu_src;
    assign bus.branchE   = r_e_q.branch;
    assign bus.jumpE     = r_e_q.jump;
    assign bus.resultSrcE = r_e_q.result_src;
    assign bus.aluOpE    = r_e_q.alu_op;
    assign bus.funct3E   = r_e_q.funct3;
    assign bus.funct7bE  = r_e_q.funct7b;
    assign bus.rdE       = r_e_q.rd;
    assign bus.rs1E      = r_e_q.rs1;
    assign bus.rs2E      = r_e_q.rs2;
    assign bus.immE      = r_e_q.imm;
    assign bus.illegalE  = r_e_q.illegal;
    assign bus.stallCnt  = r_stall_cnt_q;
    assign bus.flushCnt  = r_flush_cnt_q;
endmodule
`default_nettype wire
